// File: rtl/peregrine_pif_pkg.sv
// Shared widths, request-FSM state and request payload type for the Peregrine PIF arbiter.
package peregrine_pif_pkg;

  localparam int unsigned CNTL_W        = 8;
  localparam int unsigned ADRS_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned ID_W          = 6;
  localparam int unsigned PRI_W         = 2;
  localparam int unsigned CNTL_LAST_BIT = 0;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } reqState_e;

  // Request payload except Id, which is re-tagged separately on the way to the slave
  typedef struct packed {
    logic [CNTL_W-1:0] cntl;
    logic [ADRS_W-1:0] adrs;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [PRI_W-1:0]  pri;
  } pifReq_t;

endpackage

// File: rtl/peregrine_pif_arb_grant.sv
// Open-state grant: higher priority wins, ties go to the master that was not granted last.
module peregrine_pif_arb_grant
  import peregrine_pif_pkg::*;
(
  input  logic             valid0,
  input  logic             valid1,
  input  logic [PRI_W-1:0] pri0,
  input  logic [PRI_W-1:0] pri1,
  input  logic             rrLast,
  output logic             grant_c
);

  always_comb begin
    grant_c = 1'b0;
    if (valid0 && valid1) begin
      if (pri1 > pri0)      grant_c = 1'b1;
      else if (pri0 > pri1) grant_c = 1'b0;
      else                  grant_c = ~rrLast;
    end else if (valid1) begin
      grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/peregrine_pif_arbiter.sv
// Two-master to one-slave PIF request arbiter with burst locking and Id-bit response routing.
module peregrine_pif_arbiter
  import peregrine_pif_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  // master 0 request
  input  logic              POReqValid_M0,
  output logic              PIReqRdy_M0,
  input  logic [CNTL_W-1:0] POReqCntl_M0,
  input  logic [ADRS_W-1:0] POReqAdrs_M0,
  input  logic [DATA_W-1:0] POReqData_M0,
  input  logic [BE_W-1:0]   POReqDataBE_M0,
  input  logic [ID_W-1:0]   POReqId_M0,
  input  logic [PRI_W-1:0]  POReqPriority_M0,
  // master 1 request
  input  logic              POReqValid_M1,
  output logic              PIReqRdy_M1,
  input  logic [CNTL_W-1:0] POReqCntl_M1,
  input  logic [ADRS_W-1:0] POReqAdrs_M1,
  input  logic [DATA_W-1:0] POReqData_M1,
  input  logic [BE_W-1:0]   POReqDataBE_M1,
  input  logic [ID_W-1:0]   POReqId_M1,
  input  logic [PRI_W-1:0]  POReqPriority_M1,
  // master responses
  output logic              PIRespValid_M0,
  input  logic              PORespRdy_M0,
  output logic [CNTL_W-1:0] PIRespCntl_M0,
  output logic [DATA_W-1:0] PIRespData_M0,
  output logic [ID_W-1:0]   PIRespId_M0,
  output logic [PRI_W-1:0]  PIRespPriority_M0,
  output logic              PIRespValid_M1,
  input  logic              PORespRdy_M1,
  output logic [CNTL_W-1:0] PIRespCntl_M1,
  output logic [DATA_W-1:0] PIRespData_M1,
  output logic [ID_W-1:0]   PIRespId_M1,
  output logic [PRI_W-1:0]  PIRespPriority_M1,
  // slave request
  output logic              POReqValid_S,
  input  logic              PIReqRdy_S,
  output logic [CNTL_W-1:0] POReqCntl_S,
  output logic [ADRS_W-1:0] POReqAdrs_S,
  output logic [DATA_W-1:0] POReqData_S,
  output logic [BE_W-1:0]   POReqDataBE_S,
  output logic [ID_W-1:0]   POReqId_S,
  output logic [PRI_W-1:0]  POReqPriority_S,
  // slave response
  input  logic              PIRespValid_S,
  output logic              PORespRdy_S,
  input  logic [CNTL_W-1:0] PIRespCntl_S,
  input  logic [DATA_W-1:0] PIRespData_S,
  input  logic [ID_W-1:0]   PIRespId_S,
  input  logic [PRI_W-1:0]  PIRespPriority_S
);

  reqState_e state;
  logic      owner;
  logic      rrLast;
  logic      grantArb;
  logic      grant;
  logic      beatAccept;
  logic      isLast;
  logic      respSel;
  pifReq_t   req0;
  pifReq_t   req1;
  pifReq_t   reqSel;
  logic      unusedIdMsb;

  peregrine_pif_arb_grant u_grant (
    .valid0  (POReqValid_M0),
    .valid1  (POReqValid_M1),
    .pri0    (POReqPriority_M0),
    .pri1    (POReqPriority_M1),
    .rrLast  (rrLast),
    .grant_c (grantArb)
  );

  assign grant = (state == ST_LOCK) ? owner : grantArb;

  assign req0 = '{cntl: POReqCntl_M0, adrs: POReqAdrs_M0, data: POReqData_M0,
                  be: POReqDataBE_M0, pri: POReqPriority_M0};
  assign req1 = '{cntl: POReqCntl_M1, adrs: POReqAdrs_M1, data: POReqData_M1,
                  be: POReqDataBE_M1, pri: POReqPriority_M1};
  assign reqSel = grant ? req1 : req0;

  assign POReqCntl_S     = reqSel.cntl;
  assign POReqAdrs_S     = reqSel.adrs;
  assign POReqData_S     = reqSel.data;
  assign POReqDataBE_S   = reqSel.be;
  assign POReqPriority_S = reqSel.pri;
  // Id bit 5 carries the master index so the response can find its way back
  assign POReqId_S = {grant, grant ? POReqId_M1[ID_W-2:0] : POReqId_M0[ID_W-2:0]};
  assign unusedIdMsb = POReqId_M0[ID_W-1] ^ POReqId_M1[ID_W-1];

  // Handshake outputs are forced low while reset is held
  assign POReqValid_S = RESET_N & (grant ? POReqValid_M1 : POReqValid_M0);
  assign PIReqRdy_M0  = RESET_N & ~grant & PIReqRdy_S;
  assign PIReqRdy_M1  = RESET_N &  grant & PIReqRdy_S;

  assign beatAccept = POReqValid_S & PIReqRdy_S;
  assign isLast     = reqSel.cntl[CNTL_LAST_BIT];

  // Burst lock and round-robin history
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_OPEN;
      owner  <= 1'b0;
      rrLast <= 1'b1;
    end else if (beatAccept) begin
      case (state)
        ST_OPEN: begin
          if (isLast) begin
            rrLast <= grant;
          end else begin
            state <= ST_LOCK;
            owner <= grant;
          end
        end
        ST_LOCK: begin
          if (isLast) begin
            state  <= ST_OPEN;
            rrLast <= owner;
          end
        end
        default: state <= ST_OPEN;
      endcase
    end
  end

  // Stateless response steering on the tagged Id bit
  assign respSel        = PIRespId_S[ID_W-1];
  assign PIRespValid_M0 = RESET_N & PIRespValid_S & ~respSel;
  assign PIRespValid_M1 = RESET_N & PIRespValid_S &  respSel;
  assign PORespRdy_S    = RESET_N & (respSel ? PORespRdy_M1 : PORespRdy_M0);

  assign PIRespId_M0       = {1'b0, PIRespId_S[ID_W-2:0]};
  assign PIRespId_M1       = {1'b0, PIRespId_S[ID_W-2:0]};
  assign PIRespCntl_M0     = PIRespCntl_S;
  assign PIRespCntl_M1     = PIRespCntl_S;
  assign PIRespData_M0     = PIRespData_S;
  assign PIRespData_M1     = PIRespData_S;
  assign PIRespPriority_M0 = PIRespPriority_S;
  assign PIRespPriority_M1 = PIRespPriority_S;

endmodule

// File: tb/tb_peregrine_pif_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_peregrine_pif_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [1:0]  reqValid;
  logic [7:0]  reqCntl [2];
  logic [31:0] reqAdrs [2];
  logic [31:0] reqData [2];
  logic [3:0]  reqBe   [2];
  logic [5:0]  reqId   [2];
  logic [1:0]  reqPri  [2];
  logic [1:0]  respRdyM;
  logic        rdyM0, rdyM1;
  logic        rspValid [2];
  logic [7:0]  rspCntl  [2];
  logic [31:0] rspData  [2];
  logic [5:0]  rspId    [2];
  logic [1:0]  rspPri   [2];
  logic        sValid, sRdy;
  logic [7:0]  sCntl;
  logic [31:0] sAdrs, sData;
  logic [3:0]  sBe;
  logic [5:0]  sId;
  logic [1:0]  sPri;
  logic        slvRespValid, slvRespRdy;
  logic [7:0]  slvRespCntl;
  logic [31:0] slvRespData;
  logic [5:0]  slvRespId;
  logic [1:0]  slvRespPri;

  int nChecks = 0;
  int nErr    = 0;

  // model: is a burst in progress, who owns it, who took the last completed request
  bit mLocked, mOwner, mRrLast;

  always #5 CLK = ~CLK;

  peregrine_pif_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .POReqValid_M0(reqValid[0]), .PIReqRdy_M0(rdyM0), .POReqCntl_M0(reqCntl[0]),
    .POReqAdrs_M0(reqAdrs[0]), .POReqData_M0(reqData[0]), .POReqDataBE_M0(reqBe[0]),
    .POReqId_M0(reqId[0]), .POReqPriority_M0(reqPri[0]),
    .POReqValid_M1(reqValid[1]), .PIReqRdy_M1(rdyM1), .POReqCntl_M1(reqCntl[1]),
    .POReqAdrs_M1(reqAdrs[1]), .POReqData_M1(reqData[1]), .POReqDataBE_M1(reqBe[1]),
    .POReqId_M1(reqId[1]), .POReqPriority_M1(reqPri[1]),
    .PIRespValid_M0(rspValid[0]), .PORespRdy_M0(respRdyM[0]), .PIRespCntl_M0(rspCntl[0]),
    .PIRespData_M0(rspData[0]), .PIRespId_M0(rspId[0]), .PIRespPriority_M0(rspPri[0]),
    .PIRespValid_M1(rspValid[1]), .PORespRdy_M1(respRdyM[1]), .PIRespCntl_M1(rspCntl[1]),
    .PIRespData_M1(rspData[1]), .PIRespId_M1(rspId[1]), .PIRespPriority_M1(rspPri[1]),
    .POReqValid_S(sValid), .PIReqRdy_S(sRdy), .POReqCntl_S(sCntl), .POReqAdrs_S(sAdrs),
    .POReqData_S(sData), .POReqDataBE_S(sBe), .POReqId_S(sId), .POReqPriority_S(sPri),
    .PIRespValid_S(slvRespValid), .PORespRdy_S(slvRespRdy), .PIRespCntl_S(slvRespCntl),
    .PIRespData_S(slvRespData), .PIRespId_S(slvRespId), .PIRespPriority_S(slvRespPri)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit expGrant();
    if (mLocked) return mOwner;
    if (reqValid[0] && reqValid[1]) begin
      if (reqPri[1] > reqPri[0]) return 1'b1;
      if (reqPri[0] > reqPri[1]) return 1'b0;
      return !mRrLast;
    end
    return reqValid[1];
  endfunction

  task automatic modelReset();
    mLocked = 1'b0;
    mOwner  = 1'b0;
    mRrLast = 1'b1;
  endtask

  task automatic setReset(input logic v);
    RESET_N = v;
    if (!v) modelReset();
  endtask

  task automatic checkModel();
    bit g, sel;
    logic r;
    logic [5:0] idG;
    g   = expGrant();
    r   = RESET_N;
    idG = reqId[g];
    sel = slvRespId[5];
    chk("slvReqValid", 64'(sValid), 64'(r & reqValid[g]));
    chk("reqRdyM0",    64'(rdyM0),  64'(r & (g == 1'b0) & sRdy));
    chk("reqRdyM1",    64'(rdyM1),  64'(r & (g == 1'b1) & sRdy));
    chk("slvCntl",     64'(sCntl),  64'(reqCntl[g]));
    chk("slvAdrs",     64'(sAdrs),  64'(reqAdrs[g]));
    chk("slvData",     64'(sData),  64'(reqData[g]));
    chk("slvBe",       64'(sBe),    64'(reqBe[g]));
    chk("slvPri",      64'(sPri),   64'(reqPri[g]));
    chk("slvId",       64'(sId),    64'({g, idG[4:0]}));
    chk("slvRespRdy",  64'(slvRespRdy), 64'(r & respRdyM[sel]));
    for (int k = 0; k < 2; k++) begin
      chk("respValid", 64'(rspValid[k]), 64'(r & slvRespValid & (sel == 1'(k))));
      chk("respId",    64'(rspId[k]),    64'({1'b0, slvRespId[4:0]}));
      chk("respCntl",  64'(rspCntl[k]),  64'(slvRespCntl));
      chk("respData",  64'(rspData[k]),  64'(slvRespData));
      chk("respPri",   64'(rspPri[k]),   64'(slvRespPri));
    end
  endtask

  task automatic updateModel();
    bit g;
    logic [7:0] c;
    if (!RESET_N) begin
      modelReset();
      return;
    end
    g = expGrant();
    c = reqCntl[g];
    if (reqValid[g] && sRdy) begin
      if (mLocked) begin
        if (c[0]) begin
          mLocked = 1'b0;
          mRrLast = mOwner;
        end
      end else if (c[0]) begin
        mRrLast = g;
      end else begin
        mLocked = 1'b1;
        mOwner  = g;
      end
    end
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic advance();
    checkModel();
    updateModel();
    @(posedge CLK);
    #1;
  endtask

  task automatic setMaster(input int k, input logic [7:0] c, input logic [5:0] id, input logic [1:0] p);
    reqCntl[k] = c;
    reqId[k]   = id;
    reqPri[k]  = p;
    reqAdrs[k] = 32'h1000_0000 + 32'(k) * 32'h100 + 32'(id);
    reqData[k] = 32'hA5A5_0000 + 32'(k);
    reqBe[k]   = 4'hF;
  endtask

  initial begin
    logic [5:0] ids [3];
    logic       rdyExp [3];
    setReset(1'b0);
    reqValid = 2'b11;
    sRdy = 1'b1;
    respRdyM = 2'b11;
    slvRespValid = 1'b1;
    slvRespCntl = 8'h11;
    slvRespData = 32'hDEAD_BEEF;
    slvRespId = 6'h01;
    slvRespPri = 2'd1;
    setMaster(0, 8'h01, 6'h00, 2'd0);
    setMaster(1, 8'h01, 6'h00, 2'd0);
    repeat (2) @(posedge CLK);
    #1;

    // handshakes held low in reset
    settle();
    chk("rst_slvValid", 64'(sValid), 64'd0);
    chk("rst_rdyM0", 64'(rdyM0), 64'd0);
    chk("rst_respValidM0", 64'(rspValid[0]), 64'd0);
    chk("rst_respRdyS", 64'(slvRespRdy), 64'd0);
    advance();
    setReset(1'b1);
    slvRespValid = 1'b0;

    // equal priority single beats alternate starting with M0
    setMaster(0, 8'h01, 6'h02, 2'd1);
    setMaster(1, 8'h01, 6'h03, 2'd1);
    reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("alt_rdyM0", 64'(rdyM0), 64'(i % 2 == 0));
      chk("alt_rdyM1", 64'(rdyM1), 64'(i % 2 == 1));
      if (i % 2 == 1) chk("alt_idM1", 64'(sId), 64'h23);
      advance();
    end

    // M0 alone, Id 5, response Id 5 returns to M0
    reqValid = 2'b01;
    setMaster(0, 8'h01, 6'h05, 2'd0);
    slvRespValid = 1'b1;
    slvRespId = 6'h05;
    settle();
    chk("m0_id", 64'(sId), 64'h05);
    chk("m0_valid", 64'(sValid), 64'd1);
    chk("m0_respV0", 64'(rspValid[0]), 64'd1);
    chk("m0_respV1", 64'(rspValid[1]), 64'd0);
    advance();
    slvRespValid = 1'b0;

    // higher priority M1 keeps the grant until it drops valid
    reqValid = 2'b11;
    setMaster(0, 8'h01, 6'h01, 2'd0);
    setMaster(1, 8'h01, 6'h02, 2'd3);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("pri_rdyM1", 64'(rdyM1), 64'd1);
      chk("pri_rdyM0", 64'(rdyM0), 64'd0);
      advance();
    end
    reqValid = 2'b01;
    settle();
    chk("pri_drop_rdyM0", 64'(rdyM0), 64'd1);
    advance();

    // M0 4-beat burst locks out high-priority M1 through slave stalls
    setMaster(0, 8'h00, 6'h04, 2'd0);
    settle();
    chk("burst_b0_rdyM0", 64'(rdyM0), 64'd1);
    advance();
    reqValid = 2'b11;
    setMaster(1, 8'h01, 6'h06, 2'd3);
    sRdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("burst_stall_rdyM1", 64'(rdyM1), 64'd0);
      chk("burst_stall_valid", 64'(sValid), 64'd1);
      advance();
    end
    sRdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      reqCntl[0] = (i == 3) ? 8'h01 : 8'h00;
      settle();
      chk("burst_rdyM0", 64'(rdyM0), 64'd1);
      chk("burst_rdyM1", 64'(rdyM1), 64'd0);
      advance();
    end
    reqValid = 2'b10;
    settle();
    chk("burst_after_rdyM1", 64'(rdyM1), 64'd1);
    advance();

    // interleaved responses, M1 not ready
    reqValid = 2'b00;
    respRdyM = 2'b01;
    slvRespValid = 1'b1;
    ids[0] = 6'h21; ids[1] = 6'h01; ids[2] = 6'h21;
    rdyExp[0] = 1'b0; rdyExp[1] = 1'b1; rdyExp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slvRespId = ids[i];
      settle();
      chk("rsp_rdyS", 64'(slvRespRdy), 64'(rdyExp[i]));
      if (i != 1) begin
        chk("rsp_validM1", 64'(rspValid[1]), 64'd1);
        chk("rsp_idM1", 64'(rspId[1]), 64'h01);
      end
      advance();
    end
    slvRespValid = 1'b0;
    respRdyM = 2'b11;

    // reset during an M1 burst abandons the lock; M0 then wins a tie
    reqValid = 2'b10;
    setMaster(1, 8'h00, 6'h07, 2'd0);
    settle();
    advance();
    setReset(1'b0);
    reqValid = 2'b11;
    slvRespValid = 1'b1;
    slvRespId = 6'h21;
    settle();
    chk("rl_slvValid", 64'(sValid), 64'd0);
    chk("rl_rdyM0", 64'(rdyM0), 64'd0);
    chk("rl_rdyM1", 64'(rdyM1), 64'd0);
    chk("rl_respV1", 64'(rspValid[1]), 64'd0);
    chk("rl_respRdyS", 64'(slvRespRdy), 64'd0);
    advance();
    setReset(1'b1);
    slvRespValid = 1'b0;
    setMaster(0, 8'h01, 6'h08, 2'd2);
    setMaster(1, 8'h01, 6'h09, 2'd2);
    settle();
    chk("rl_tie_rdyM0", 64'(rdyM0), 64'd1);
    chk("rl_tie_rdyM1", 64'(rdyM1), 64'd0);
    advance();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        reqValid[k] = ($urandom_range(3) != 0);
        reqCntl[k]  = 8'($urandom);
        reqAdrs[k]  = $urandom;
        reqData[k]  = $urandom;
        reqBe[k]    = 4'($urandom);
        reqId[k]    = 6'($urandom);
        reqPri[k]   = 2'($urandom);
      end
      sRdy         = ($urandom_range(3) != 0);
      respRdyM     = 2'($urandom);
      slvRespValid = 1'($urandom);
      slvRespCntl  = 8'($urandom);
      slvRespData  = $urandom;
      slvRespId    = 6'($urandom);
      slvRespPri   = 2'($urandom);
      setReset(($urandom_range(199) != 0));
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/peregrine_pif_arbiter.md
# peregrine_pif_arbiter

Two-master to one-slave PIF request arbiter and response router for the Peregrine XTSC cosim bench. It lets a second PIF master, such as a DMA model or test injector, share the single slave PIF with the core.
- Requests: arbitrated by priority, with round-robin tie-break.
- Multi-beat requests: locked to one master until the last beat.
- Responses: steered back by one ID bit that the arbiter inserts.

## Interface
Parameters:
- none. PIF widths are fixed: Cntl 8, Adrs 32, Data 32, DataBE 4, Id 6, Priority 2.

Ports:
- CLK  input  1  single clock; all state on rising edge
- RESET_N  input  1  reset, asynchronous assert, active-low
- POReqValid_M0, POReqValid_M1  input  1  master request valid
- PIReqRdy_M0, PIReqRdy_M1  output  1  request ready to master
- POReqCntl_M0/M1, POReqAdrs_M0/M1, POReqData_M0/M1, POReqDataBE_M0/M1, POReqId_M0/M1, POReqPriority_M0/M1  input  8/32/32/4/6/2  master request payload
- PIRespValid_M0, PIRespValid_M1  output  1  response valid to master
- PORespRdy_M0, PORespRdy_M1  input  1  master response ready
- PIRespCntl_M0/M1, PIRespData_M0/M1, PIRespId_M0/M1, PIRespPriority_M0/M1  output  8/32/6/2  response payload
- POReqValid_S  output  1  slave request valid
- PIReqRdy_S  input  1  slave request ready
- POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S, POReqId_S, POReqPriority_S  output  8/32/32/4/6/2  slave request payload
- PIRespValid_S  input  1  slave response valid
- PORespRdy_S  output  1  response ready to slave
- PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S  input  8/32/6/2  slave response payload

## Operation
- Beat accepted: POReqValid_S & PIReqRdy_S. Last beat: POReqCntl[0]=1.
- Request FSM has two states.
  - OPEN: grant goes to the valid master with numerically higher POReqPriority. On equal priority, grant goes to the master whose index differs from rr_last. With one valid master, it gets the grant.
  - LOCK(owner): grant is fixed to owner. The other master is ignored regardless of priority.
- FSM transitions:
  - OPEN -> LOCK(g) when a non-last beat is accepted.
  - LOCK -> OPEN when the owner's last beat is accepted.
  - Single-beat requests stay in OPEN.
- rr_last is set to the granted index on every accepted last beat.
- Granted master k drives the slave payload.
  - POReqValid_S = POReqValid_Mk.
  - PIReqRdy_Mk = PIReqRdy_S.
  - The non-granted master sees PIReqRdy=0.
  - With no valid master, payload follows M0 and POReqValid_S=0.
- In OPEN, the grant may change before acceptance, for example when a higher-priority request arrives. This is legal because PIF commits only on acceptance.
- ID tagging: POReqId_S = {k, POReqId_Mk[4:0]}. Masters must issue IDs with bit 5 = 0; bit 5 is overwritten silently.
- Response routing (combinational, stateless):
  - sel = PIRespId_S[5].
  - PIRespValid_Msel = PIRespValid_S; the other master's response valid = 0.
  - PORespRdy_S = PORespRdy_Msel.
  - PIRespId_Mx = {1'b0, PIRespId_S[4:0]}.
  - Cntl, Data and Priority are broadcast to both masters.

## Timing
- Zero-cycle latency on both paths; grant is a combinational function of the FSM state and inputs.
- Reset: FSM=OPEN, rr_last=1 so M0 wins the first tie.
- While RESET_N=0, these outputs are 0: POReqValid_S, PIReqRdy_M0/M1, PIRespValid_M0/M1, PORespRdy_S. Payload outputs follow the mux.
- Reset asserted mid-burst: LOCK is abandoned and the FSM returns to OPEN. Masters must be reset together with the arbiter.
- Owner drops valid mid-burst: FSM stays in LOCK. No other master is granted until the last beat.
- Simultaneous last-beat acceptance and a new request from the other master: the new request sees the grant on the next cycle.

## Structure
- Package peregrine_pif_pkg holds:
  - width constants: CNTL_W=8, ADRS_W=32, DATA_W=32, BE_W=4, ID_W=6, PRI_W=2
  - CNTL_LAST_BIT=0
  - the FSM state enum.
- Sub-module peregrine_pif_arb_grant is natural: priority compare plus round-robin tie-break, taking valids, priorities and rr_last, and producing the grant index.

## Test plan
- M0 only: single-beat read, Id=6'h05, Priority=0 -> POReqId_S=6'h05 in the same cycle. Response Id=6'h05 -> PIRespValid_M0=1, PIRespValid_M1=0.
- Both valid, equal priority, single beats back to back -> grants alternate M0, M1, M0, M1. M1's request Id=6'h03 appears as 6'h23.
- M0 Priority=0, M1 Priority=3, both valid in OPEN -> M1 granted every cycle until it drops valid.
- M0 4-beat write (Cntl[0]=0,0,0,1) with PIReqRdy_S stalling 2 cycles, M1 Priority=3 valid throughout -> all 4 M0 beats complete before M1 gets any ready.
- Interleaved responses from the slave, Ids 6'h21, 6'h01, 6'h21, with PORespRdy_M1=0 -> PORespRdy_S=0 only on Id 6'h21 beats. M1 receives Id 6'h01.
- RESET_N pulsed low during LOCK -> all valid/ready outputs 0 during reset. After release, FSM is OPEN and M0 wins a tie.
